// File: rtl/mem_access_stage.sv
// mem_access_stage: EXE/MEM and MEM/WB pipeline registers with a req/ready
// data-memory handshake. The pipeline stalls while a memory access waits for
// dm_ready.
// Optional feature macro: MEM_TIMEOUT_EN adds a wait-cycle counter that
// abandons an access after TIMEOUT cycles and reports it on mem_timeout.
module mem_access_stage #(
  parameter int DATA_W = 32
`ifdef MEM_TIMEOUT_EN
  ,
  parameter int TIMEOUT = 16
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ewreg,
  input  logic              em2reg,
  input  logic              ewmem,
  input  logic [4:0]        ern,
  input  logic [DATA_W-1:0] r,
  input  logic [DATA_W-1:0] eqb,
  output logic              dm_req,
  output logic              dm_we,
  output logic [DATA_W-1:0] dm_addr,
  output logic [DATA_W-1:0] dm_wdata,
  input  logic [DATA_W-1:0] dm_rdata,
  input  logic              dm_ready,
  output logic              mem_stall,
  output logic              wwreg,
  output logic              wm2reg,
  output logic [4:0]        wrn,
  output logic [DATA_W-1:0] walu,
  output logic [DATA_W-1:0] wmo,
`ifdef MEM_TIMEOUT_EN
  output logic              mem_timeout,
`endif
  output logic              align_err
);

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  state_t state;
  state_t state_next;

  // EXE/MEM register
  logic              mwreg;
  logic              mm2reg;
  logic              mwmem;
  logic [4:0]        mrn;
  logic [DATA_W-1:0] malu;
  logic [DATA_W-1:0] mqb;

  // Classification of the instruction currently presented by EXE
  logic in_memop;
  logic in_aligned;
  logic in_misaligned;
  logic in_access;

  // The access in flight finishes this cycle, either by dm_ready or by timeout
  logic timeout_hit;
  logic load_done;

  assign in_memop      = em2reg | ewmem;
  assign in_aligned    = (r[1:0] == 2'b00);
  assign in_misaligned = in_memop & ~in_aligned;
  assign in_access     = in_memop & in_aligned;

  assign dm_addr  = malu;
  assign dm_wdata = mqb;

  // Only a load that really received data from memory returns dm_rdata
  assign load_done = (state == ACCESS) & mm2reg & dm_ready;

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [CNT_W-1:0] wait_cnt;

  assign timeout_hit = (state == ACCESS) & ~dm_ready &
                       (wait_cnt == CNT_W'(TIMEOUT - 1));

  // Wait counter: zero whenever the pipeline advances, counts stalled ACCESS cycles
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt <= '0;
    end else if (mem_stall) begin
      wait_cnt <= wait_cnt + CNT_W'(1);
    end else begin
      wait_cnt <= '0;
    end
  end

  // Sticky flag recording that some access was abandoned
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_timeout <= 1'b0;
    end else if (timeout_hit) begin
      mem_timeout <= 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // FSM next state and handshake outputs; when the pipeline advances the
  // next state is decided by the instruction entering the M-regs
  always_comb begin
    state_next = state;
    dm_req     = 1'b0;
    dm_we      = 1'b0;
    mem_stall  = 1'b0;
    case (state)
      IDLE: begin
        state_next = in_access ? ACCESS : IDLE;
      end
      ACCESS: begin
        dm_req = 1'b1;
        dm_we  = mwmem;
        if (dm_ready || timeout_hit) begin
          state_next = in_access ? ACCESS : IDLE;
        end else begin
          mem_stall = 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // EXE/MEM register: captures EXE whenever the pipeline is not frozen; a
  // misaligned load loses its register write here so it can never retire data
  always_ff @(posedge clk) begin
    if (rst) begin
      mwreg  <= 1'b0;
      mm2reg <= 1'b0;
      mwmem  <= 1'b0;
      mrn    <= '0;
      malu   <= '0;
      mqb    <= '0;
    end else if (!mem_stall) begin
      mwreg  <= ewreg & ~(em2reg & in_misaligned);
      mm2reg <= em2reg;
      mwmem  <= ewmem;
      mrn    <= ern;
      malu   <= r;
      mqb    <= eqb;
    end
  end

  // Sticky misalignment flag, raised when a misaligned op enters the M-regs
  always_ff @(posedge clk) begin
    if (rst) begin
      align_err <= 1'b0;
    end else if (!mem_stall && in_misaligned) begin
      align_err <= 1'b1;
    end
  end

  // MEM/WB register: advances with the pipeline, inserts bubbles while stalled
  // so a waiting instruction is written back exactly once
  always_ff @(posedge clk) begin
    if (rst) begin
      wwreg  <= 1'b0;
      wm2reg <= 1'b0;
      wrn    <= '0;
      walu   <= '0;
      wmo    <= '0;
    end else if (!mem_stall) begin
      wwreg  <= mwreg & ~(mm2reg & timeout_hit);
      wm2reg <= mm2reg;
      wrn    <= mrn;
      walu   <= malu;
      wmo    <= load_done ? dm_rdata : '0;
    end else begin
      wwreg  <= 1'b0;
      wm2reg <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage: directed self-checking bench for mem_access_stage.
module tb_mem_access_stage;

  logic        clk;
  logic        rst;
  logic        ewreg;
  logic        em2reg;
  logic        ewmem;
  logic [4:0]  ern;
  logic [31:0] r;
  logic [31:0] eqb;
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [31:0] dm_rdata;
  logic        dm_ready;
  logic        mem_stall;
  logic        wwreg;
  logic        wm2reg;
  logic [4:0]  wrn;
  logic [31:0] walu;
  logic [31:0] wmo;
  logic        align_err;
`ifdef MEM_TIMEOUT_EN
  logic        mem_timeout;
`endif

  int total;
  int bad;

  mem_access_stage #(
    .DATA_W(32)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .ewreg    (ewreg),
    .em2reg   (em2reg),
    .ewmem    (ewmem),
    .ern      (ern),
    .r        (r),
    .eqb      (eqb),
    .dm_req   (dm_req),
    .dm_we    (dm_we),
    .dm_addr  (dm_addr),
    .dm_wdata (dm_wdata),
    .dm_rdata (dm_rdata),
    .dm_ready (dm_ready),
    .mem_stall(mem_stall),
    .wwreg    (wwreg),
    .wm2reg   (wm2reg),
    .wrn      (wrn),
    .walu     (walu),
    .wmo      (wmo),
`ifdef MEM_TIMEOUT_EN
    .mem_timeout(mem_timeout),
`endif
    .align_err(align_err)
  );

  // Free-running clock, period 10
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Present one EXE-stage instruction
  task automatic applyStimulus(input logic wreg, input logic m2reg,
                               input logic wmem, input logic [4:0] rn,
                               input logic [31:0] alu, input logic [31:0] qb);
    ewreg  = wreg;
    em2reg = m2reg;
    ewmem  = wmem;
    ern    = rn;
    r      = alu;
    eqb    = qb;
  endtask

  // Advance one edge and settle away from it
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // One comparison point
  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $display("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
      $error("[TB] assertion on %s", tag);
    end
  endtask

  initial begin
    total    = 0;
    bad      = 0;
    rst      = 1'b1;
    dm_ready = 1'b0;
    dm_rdata = 32'h0;
    applyStimulus(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0);

    // Reset
    tick();
    tick();
    checkOutput("rst_dm_req", dm_req, 32'd0);
    checkOutput("rst_stall", mem_stall, 32'd0);
    checkOutput("rst_wwreg", wwreg, 32'd0);
    checkOutput("rst_walu", walu, 32'd0);
    checkOutput("rst_align", align_err, 32'd0);
    rst = 1'b0;

    // Plain ALU op
    applyStimulus(1'b1, 1'b0, 1'b0, 5'd5, 32'h10, 32'h0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
    #1;
    checkOutput("alu_dm_req", dm_req, 32'd0);
    checkOutput("alu_stall", mem_stall, 32'd0);
    tick();
    checkOutput("alu_wwreg", wwreg, 32'd1);
    checkOutput("alu_wrn", wrn, 32'd5);
    checkOutput("alu_walu", walu, 32'h10);
    checkOutput("alu_wmo", wmo, 32'h0);
    checkOutput("alu_wm2reg", wm2reg, 32'd0);

    // Load with three wait cycles
    applyStimulus(1'b1, 1'b1, 1'b0, 5'd7, 32'h40, 32'h0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      #1;
      checkOutput("ld_wait_req", dm_req, 32'd1);
      checkOutput("ld_wait_we", dm_we, 32'd0);
      checkOutput("ld_wait_addr", dm_addr, 32'h40);
      checkOutput("ld_wait_stall", mem_stall, 32'd1);
      tick();
      checkOutput("ld_bubble_wwreg", wwreg, 32'd0);
    end
    dm_ready = 1'b1;
    dm_rdata = 32'hDEADBEEF;
    #1;
    checkOutput("ld_done_req", dm_req, 32'd1);
    checkOutput("ld_done_addr", dm_addr, 32'h40);
    checkOutput("ld_done_stall", mem_stall, 32'd0);
    tick();
    dm_ready = 1'b0;
    dm_rdata = 32'h0;
    #1;
    checkOutput("ld_wb_wwreg", wwreg, 32'd1);
    checkOutput("ld_wb_wm2reg", wm2reg, 32'd1);
    checkOutput("ld_wb_wrn", wrn, 32'd7);
    checkOutput("ld_wb_wmo", wmo, 32'hDEADBEEF);
    checkOutput("ld_after_req", dm_req, 32'd0);
    tick();
    checkOutput("ld_once_wwreg", wwreg, 32'd0);
    checkOutput("ld_once_wmo", wmo, 32'h0);

    // Store then load, zero-wait memory
    dm_ready = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b1, 5'd0, 32'h80, 32'h12345678);
    tick();
    applyStimulus(1'b1, 1'b1, 1'b0, 5'd9, 32'h84, 32'h0);
    #1;
    checkOutput("st_req", dm_req, 32'd1);
    checkOutput("st_we", dm_we, 32'd1);
    checkOutput("st_addr", dm_addr, 32'h80);
    checkOutput("st_wdata", dm_wdata, 32'h12345678);
    checkOutput("st_stall", mem_stall, 32'd0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
    dm_rdata = 32'hCAFEF00D;
    #1;
    checkOutput("b2b_req", dm_req, 32'd1);
    checkOutput("b2b_we", dm_we, 32'd0);
    checkOutput("b2b_addr", dm_addr, 32'h84);
    checkOutput("b2b_stall", mem_stall, 32'd0);
    checkOutput("st_wb_wwreg", wwreg, 32'd0);
    tick();
    dm_ready = 1'b0;
    dm_rdata = 32'h0;
    #1;
    checkOutput("b2b_after_req", dm_req, 32'd0);
    checkOutput("b2b_wwreg", wwreg, 32'd1);
    checkOutput("b2b_wrn", wrn, 32'd9);
    checkOutput("b2b_wmo", wmo, 32'hCAFEF00D);

    // Misaligned load followed by an ALU op
    applyStimulus(1'b1, 1'b1, 1'b0, 5'd3, 32'h42, 32'h0);
    tick();
    applyStimulus(1'b1, 1'b0, 1'b0, 5'd4, 32'h55, 32'h0);
    #1;
    checkOutput("mis_req", dm_req, 32'd0);
    checkOutput("mis_stall", mem_stall, 32'd0);
    checkOutput("mis_align", align_err, 32'd1);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
    #1;
    checkOutput("mis_wwreg", wwreg, 32'd0);
    checkOutput("mis_wmo", wmo, 32'h0);
    checkOutput("mis_req2", dm_req, 32'd0);
    tick();
    checkOutput("mis_next_wwreg", wwreg, 32'd1);
    checkOutput("mis_next_wrn", wrn, 32'd4);
    checkOutput("mis_next_walu", walu, 32'h55);
    checkOutput("mis_sticky", align_err, 32'd1);

    // Reset in the middle of a stalled access, with a coincident dm_ready
    applyStimulus(1'b1, 1'b0, 1'b0, 5'd6, 32'h77, 32'h0);
    tick();
    applyStimulus(1'b1, 1'b1, 1'b0, 5'd11, 32'h100, 32'h0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
    #1;
    checkOutput("rstm_pre_req", dm_req, 32'd1);
    checkOutput("rstm_pre_stall", mem_stall, 32'd1);
    checkOutput("rstm_pre_walu", walu, 32'h77);
    checkOutput("rstm_pre_wwreg", wwreg, 32'd1);
    rst      = 1'b1;
    dm_ready = 1'b1;
    dm_rdata = 32'hFFFFFFFF;
    tick();
    rst      = 1'b0;
    dm_ready = 1'b0;
    dm_rdata = 32'h0;
    #1;
    checkOutput("rstm_req", dm_req, 32'd0);
    checkOutput("rstm_stall", mem_stall, 32'd0);
    checkOutput("rstm_wwreg", wwreg, 32'd0);
    checkOutput("rstm_wm2reg", wm2reg, 32'd0);
    checkOutput("rstm_wrn", wrn, 32'd0);
    checkOutput("rstm_walu", walu, 32'h0);
    checkOutput("rstm_wmo", wmo, 32'h0);
    checkOutput("rstm_align", align_err, 32'd0);
    tick();
    checkOutput("rstm_post_req", dm_req, 32'd0);
    checkOutput("rstm_post_wwreg", wwreg, 32'd0);

`ifdef MEM_TIMEOUT_EN
    // Load that never completes is abandoned after 16 cycles
    applyStimulus(1'b1, 1'b1, 1'b0, 5'd12, 32'h200, 32'h0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
    for (int i = 0; i < 16; i++) begin
      #1;
      checkOutput("to_req", dm_req, 32'd1);
      tick();
    end
    #1;
    checkOutput("to_after_req", dm_req, 32'd0);
    checkOutput("to_flag", mem_timeout, 32'd1);
    checkOutput("to_wwreg", wwreg, 32'd0);
    checkOutput("to_wm2reg", wm2reg, 32'd1);
    checkOutput("to_wmo", wmo, 32'h0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
